lsu_responder: RTL

- Memory-side responder for the LSU request interface used by the core and the accelerators (lsu_ren/lsu_wen/lsu_type/base/offset/wdata -> lsu_done/lsu_rdata).
- Forms the effective address and checks alignment.
- Runs one transaction at a time on the data bus using a req/gnt/rvalid handshake, with byte enables and lane steering.
- Returns a registered single-cycle lsu_done with read data and an error flag.

---
 rtl/lsu_responder_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/lsu_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_responder_pkg.sv
// Shared encodings, FSM states and bus payload type for the LSU memory-side responder.
package lsu_responder_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   localparam logic [1:0] DATA_BYTE = 2'd0;
   localparam logic [1:0] DATA_HALF = 2'd1;
   localparam logic [1:0] DATA_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } bus_req_t;

   // Type 3 is reserved; halves need even and words need 4-byte alignment.
   function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] ea_lo);
      logic bad;
      case (size)
         DATA_BYTE: bad = 1'b0;
         DATA_HALF: bad = ea_lo[0];
         DATA_WORD: bad = (ea_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: byte enables, write-data steering and read extract/extend.
module lsu_lane_align
   import lsu_responder_pkg::*;
(
   input  logic [1:0]      size,
   input  logic [1:0]      ea_lo,
   input  logic            sext,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [BE_W-1:0] be_c,
   output logic [XLEN-1:0] wdata_c,
   output logic [XLEN-1:0] rdata_c
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] rshift;

   assign shamt   = {ea_lo, 3'b000};
   assign wdata_c = wdata << shamt;
   assign rshift  = rdata >> shamt;

   always_comb begin
      be_c    = '0;
      rdata_c = rshift;
      case (size)
         DATA_BYTE: begin
            be_c    = BE_W'(1) << ea_lo;
            rdata_c = {{(XLEN-8){sext & rshift[7]}}, rshift[7:0]};
         end
         DATA_HALF: begin
            be_c    = BE_W'(3) << ea_lo;
            rdata_c = {{(XLEN-16){sext & rshift[15]}}, rshift[15:0]};
         end
         DATA_WORD: begin
            be_c    = '1;
            rdata_c = rshift;
         end
         default: begin
            be_c    = '0;
            rdata_c = rshift;
         end
      endcase
   end

endmodule

// File: rtl/lsu_responder.sv
// Memory-side LSU responder: one req/gnt/rvalid bus transaction per request,
// registered single-cycle completion with read data and error flag.
module lsu_responder
   import lsu_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            lsu_ren,
   input  logic            lsu_wen,
   input  logic [1:0]      lsu_type,
   input  logic            lsu_sext,
   input  logic [XLEN-1:0] lsu_addr_base,
   input  logic [XLEN-1:0] lsu_addr_offset,
   input  logic [XLEN-1:0] lsu_wdata,
   output logic            lsu_done,
   output logic [XLEN-1:0] lsu_rdata,
   output logic            lsu_err,
   output logic            data_req,
   input  logic            data_gnt,
   output logic [XLEN-1:0] data_addr,
   output logic            data_we,
   output logic [BE_W-1:0] data_be,
   output logic [XLEN-1:0] data_wdata,
   input  logic            data_rvalid,
   input  logic [XLEN-1:0] data_rdata
);

   localparam int unsigned CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

   lsu_state_e          state_q, state_d;
   bus_req_t            bus_q, bus_d;
   logic                req_q, req_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic [1:0]          ea_lo_q, ea_lo_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   logic [XLEN-1:0] ea_c;
   logic [1:0]      al_size_c, al_ea_lo_c;
   logic            al_sext_c;
   logic [BE_W-1:0] be_c;
   logic [XLEN-1:0] wdata_c, rdata_c;

   assign ea_c = lsu_addr_base + lsu_addr_offset;

   // Live request fields feed the aligner while idle; latched ones afterwards.
   assign al_size_c  = (state_q == ST_IDLE) ? lsu_type  : size_q;
   assign al_ea_lo_c = (state_q == ST_IDLE) ? ea_c[1:0] : ea_lo_q;
   assign al_sext_c  = (state_q == ST_IDLE) ? lsu_sext  : sext_q;

   lsu_lane_align u_align (
      .size    (al_size_c),
      .ea_lo   (al_ea_lo_c),
      .sext    (al_sext_c),
      .wdata   (lsu_wdata),
      .rdata   (data_rdata),
      .be_c    (be_c),
      .wdata_c (wdata_c),
      .rdata_c (rdata_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bus_q   <= '0;
         req_q   <= 1'b0;
         size_q  <= DATA_BYTE;
         sext_q  <= 1'b0;
         ea_lo_q <= 2'b00;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         req_q   <= req_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         ea_lo_q <= ea_lo_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      req_d   = req_q;
      size_d  = size_q;
      sext_d  = sext_q;
      ea_lo_d = ea_lo_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (lsu_ren || lsu_wen) begin
               if ((lsu_ren && lsu_wen) || access_illegal(lsu_type, ea_c[1:0])) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  req_d       = 1'b1;
                  bus_d.addr  = {ea_c[XLEN-1:2], 2'b00};
                  bus_d.we    = lsu_wen;
                  bus_d.be    = be_c;
                  bus_d.wdata = wdata_c;
                  size_d      = lsu_type;
                  sext_d      = lsu_sext;
                  ea_lo_d     = ea_c[1:0];
               end
            end
         end
         ST_REQ: begin
            if (data_gnt) begin
               state_d = ST_RESP;
               req_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_RESP: begin
            if (data_rvalid) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               rdata_d = bus_q.we ? '0 : rdata_c;
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
               if (TO_EN && (cnt_q == TO_LAST)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign lsu_done   = done_q;
   assign lsu_rdata  = rdata_q;
   assign lsu_err    = err_q;
   assign data_req   = req_q;
   assign data_addr  = bus_q.addr;
   assign data_we    = bus_q.we;
   assign data_be    = bus_q.be;
   assign data_wdata = bus_q.wdata;

endmodule
